nco_sweep_ctrl: RTL and testbench

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

---
 rtl/nco_sweep_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl
//   Steps an NCO through a list of phase increments. For every frequency it
//   first lets the NCO pipeline flush (LAT enabled cycles), then forwards
//   cfg_dwell valid samples downstream before it moves to the next frequency.
//
// Parameters
//   APR   phase-increment width (NCO accumulator width)
//   CNTW  width of the step-count and dwell-count fields
//   LAT   NCO latency in enabled cycles (must be >= 1)
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   start, abort       single-cycle sweep request / cancel
//   cfg_start_inc      first phase increment
//   cfg_step_inc       two's-complement increment added per step
//   cfg_nsteps         number of frequencies (0 = start ignored)
//   cfg_dwell          valid samples per frequency (0 treated as 1)
//   sink_ready         downstream can accept a sample
//   nco_out_valid      NCO output valid
//   phi_inc_o          NCO phase increment
//   nco_clken          NCO clock enable
//   sample_valid       current NCO sample belongs to the sweep
//   step_idx           index of the current frequency
//   busy               sweep in progress
//   done               one-cycle sweep-complete pulse
//
// Build option
//   NCO_SWEEP_CTRL_WRAP_EN  continuous sweep: after the last step the sweep
//                           restarts at step 0 until aborted, pulsing done
//                           once per completed pass.

module nco_sweep_ctrl #(
  parameter int unsigned APR  = 32,
  parameter int unsigned CNTW = 16,
  parameter int unsigned LAT  = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  input  logic [APR-1:0]  cfg_start_inc,
  input  logic [APR-1:0]  cfg_step_inc,
  input  logic [CNTW-1:0] cfg_nsteps,
  input  logic [CNTW-1:0] cfg_dwell,
  input  logic            sink_ready,
  input  logic            nco_out_valid,
  output logic [APR-1:0]  phi_inc_o,
  output logic            nco_clken,
  output logic            sample_valid,
  output logic [CNTW-1:0] step_idx,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_DWELL,
    S_STEP,
    S_DONE
  } state_t;

  localparam logic [CNTW-1:0] LAT_LAST = CNTW'(LAT - 1);
  localparam logic [CNTW-1:0] ONE      = CNTW'(1);

  state_t          state_q, state_d;
  logic [APR-1:0]  phi_q, phi_d;
  logic [CNTW-1:0] idx_q, idx_d;
  logic [APR-1:0]  start_inc_q, start_inc_d;
  logic [APR-1:0]  step_inc_q, step_inc_d;
  logic [CNTW-1:0] nsteps_q, nsteps_d;
  logic [CNTW-1:0] dwell_q, dwell_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            en_q, en_d;
  logic            dv_q, dv_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // State-decoded enables are flops; only the handshake inputs are gated in
  // combinationally so clken follows sink_ready in the same cycle.
  assign nco_clken    = en_q & sink_ready;
  assign sample_valid = dv_q & sink_ready & nco_out_valid;
  assign phi_inc_o    = phi_q;
  assign step_idx     = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;

  always_comb begin
    state_d     = state_q;
    phi_d       = phi_q;
    idx_d       = idx_q;
    start_inc_d = start_inc_q;
    step_inc_d  = step_inc_q;
    nsteps_d    = nsteps_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort && (cfg_nsteps != '0)) begin
          start_inc_d = cfg_start_inc;
          step_inc_d  = cfg_step_inc;
          nsteps_d    = cfg_nsteps;
          dwell_d     = (cfg_dwell == '0) ? ONE : cfg_dwell;
          phi_d       = cfg_start_inc;
          idx_d       = '0;
          cnt_d       = '0;
          state_d     = S_PRIME;
        end
      end

      // Count enabled cycles only; a downstream stall freezes the NCO, so
      // the pipeline flush must pause with it.
      S_PRIME: begin
        if (nco_clken) begin
          if (cnt_q == LAT_LAST) begin
            cnt_d   = '0;
            state_d = S_DWELL;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end

      S_DWELL: begin
        if (sample_valid) begin
          if (cnt_q == (dwell_q - ONE)) begin
            cnt_d   = '0;
            state_d = S_STEP;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end

      S_STEP: begin
        if (idx_q == (nsteps_q - ONE)) begin
`ifdef NCO_SWEEP_CTRL_WRAP_EN
          idx_d   = '0;
          phi_d   = start_inc_q;
          done_d  = 1'b1;
          state_d = S_PRIME;
`else
          done_d  = 1'b1;
          state_d = S_DONE;
`endif
        end else begin
          idx_d   = idx_q + ONE;
          phi_d   = phi_q + step_inc_q;
          state_d = S_PRIME;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cancel overrides whatever the state wanted: the current frequency and
    // index stay visible, and no completion is reported.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      phi_d   = phi_q;
      idx_d   = idx_q;
      cnt_d   = '0;
      done_d  = 1'b0;
    end

    en_d   = (state_d == S_PRIME) || (state_d == S_DWELL);
    dv_d   = (state_d == S_DWELL);
    busy_d = (state_d == S_PRIME) || (state_d == S_DWELL) || (state_d == S_STEP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      phi_q       <= '0;
      idx_q       <= '0;
      start_inc_q <= '0;
      step_inc_q  <= '0;
      nsteps_q    <= '0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      dv_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phi_q       <= phi_d;
      idx_q       <= idx_d;
      start_inc_q <= start_inc_d;
      step_inc_q  <= step_inc_d;
      nsteps_q    <= nsteps_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      dv_q        <= dv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Testbench for nco_sweep_ctrl: expected samples (phase increment and step
// index per sample) are queued when a sweep is issued; a monitor pops and
// compares them whenever sample_valid is seen.

module tb_nco_sweep_ctrl;

  localparam int unsigned APR  = 32;
  localparam int unsigned CNTW = 16;
  localparam int unsigned LAT  = 6;

`ifdef NCO_SWEEP_CTRL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start, abort;
  logic [APR-1:0]  cfg_start_inc, cfg_step_inc;
  logic [CNTW-1:0] cfg_nsteps, cfg_dwell;
  logic            sink_ready, nco_out_valid;
  logic [APR-1:0]  phi_inc_o;
  logic            nco_clken, sample_valid, busy, done;
  logic [CNTW-1:0] step_idx;

  nco_sweep_ctrl #(.APR(APR), .CNTW(CNTW), .LAT(LAT)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .cfg_start_inc (cfg_start_inc),
    .cfg_step_inc  (cfg_step_inc),
    .cfg_nsteps    (cfg_nsteps),
    .cfg_dwell     (cfg_dwell),
    .sink_ready    (sink_ready),
    .nco_out_valid (nco_out_valid),
    .phi_inc_o     (phi_inc_o),
    .nco_clken     (nco_clken),
    .sample_valid  (sample_valid),
    .step_idx      (step_idx),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [APR-1:0]  phi;
    logic [CNTW-1:0] idx;
    bit              first;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int samp_seen = 0;
  int pre_cnt = 0;
  bit chk_prime = 1'b1;
  int mode = 0;  // 0: ready/valid high, 1: ready toggles, 2: both random

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshake driver
  initial begin
    sink_ready    = 1'b1;
    nco_out_valid = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1: begin sink_ready = ~sink_ready; nco_out_valid = 1'b1; end
        2: begin sink_ready = 1'($urandom); nco_out_valid = 1'($urandom); end
        default: begin sink_ready = 1'b1; nco_out_valid = 1'b1; end
      endcase
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset_n) begin
      if (nco_clken && !sink_ready) chk("clken_without_ready", 1, 0);
      if (!busy && (nco_clken || sample_valid)) chk("activity_while_not_busy", 1, 0);
      if (done) begin
        done_seen++;
        chk("busy_at_done", busy, WRAP);
      end
      if (sample_valid) begin
        samp_seen++;
        if (exp_q.size() == 0) begin
          chk("sample_expected", 0, 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sample_phi", phi_inc_o, e.phi);
          chk("sample_idx", step_idx, e.idx);
          if (e.first && chk_prime) chk("prime_enabled_cycles", pre_cnt, LAT);
        end
        pre_cnt = 0;
      end else if (nco_clken) begin
        pre_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: frequency i of a pass is start + i*step (mod 2^APR), each
  // held for max(dwell,1) samples.
  task automatic push_sweep(input logic [APR-1:0] s, input logic [APR-1:0] st,
                            input int n, input int d, input int passes);
    int deff;
    deff = (d == 0) ? 1 : d;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < n; i++)
        for (int k = 0; k < deff; k++) begin
          exp_t e;
          e.phi   = s + APR'(i) * st;
          e.idx   = CNTW'(i);
          e.first = (k == 0);
          exp_q.push_back(e);
        end
  endtask

  task automatic issue_start(input logic [APR-1:0] s, input logic [APR-1:0] st,
                             input int n, input int d);
    cfg_start_inc = s;
    cfg_step_inc  = st;
    cfg_nsteps    = CNTW'(n);
    cfg_dwell     = CNTW'(d);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit got;
    got = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic run_sweep(input logic [APR-1:0] s, input logic [APR-1:0] st,
                           input int n, input int d, input int m, input bit cp);
    int s0, d0, deff;
    logic [APR-1:0] last;
    deff = (d == 0) ? 1 : d;
    mode = m;
    chk_prime = cp;
    tick();
    pre_cnt = 0;
    push_sweep(s, st, n, d, 1);
    s0 = samp_seen;
    d0 = done_seen;
    issue_start(s, st, n, d);
    wait_done(5000);
    tick();
    tick();
    last = s + APR'(n - 1) * st;
    chk("busy_after_sweep", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
    chk("sample_total", samp_seen - s0, n * deff);
    chk("done_pulses", done_seen - d0, 1);
    chk("phi_hold", phi_inc_o, last);
    chk("idx_hold", step_idx, n - 1);
    exp_q.delete();
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_start_inc = '0;
    cfg_step_inc = '0;
    cfg_nsteps = '0;
    cfg_dwell = '0;
    #20;
    chk("rst_phi", phi_inc_o, 0);
    chk("rst_clken", nco_clken, 0);
    chk("rst_sv", sample_valid, 0);
    chk("rst_idx", step_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #2 reset_n = 1'b1;
    tick();

`ifdef NCO_SWEEP_CTRL_WRAP_EN
    begin : wrap_test
      int d0;
      mode = 0;
      chk_prime = 1'b1;
      pre_cnt = 0;
      push_sweep(32'h0100_0000, 32'h0010_0000, 2, 1, 3);
      d0 = done_seen;
      issue_start(32'h0100_0000, 32'h0010_0000, 2, 1);
      wait_done(2000);
      wait_done(2000);
      wait_done(2000);
      chk("wrap_queue_drained", exp_q.size(), 0);
      tick();
      chk("wrap_busy_held", busy, 1);
      chk("wrap_done_count", done_seen - d0, 3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("wrap_abort_busy", busy, 0);
      exp_q.delete();
    end
`else
    // Basic sweep, all handshakes high
    run_sweep(32'h0100_0000, 32'h0010_0000, 3, 4, 0, 1'b1);
    // Same config with sink_ready toggling every cycle
    run_sweep(32'h0100_0000, 32'h0010_0000, 3, 4, 1, 1'b1);
    // Phase increment wraps modulo 2^APR
    run_sweep(32'hFFFF_FF00, 32'h0000_0200, 2, 2, 0, 1'b1);
    // Dwell of zero behaves as one
    run_sweep(32'h0000_1000, 32'hFFFF_F000, 3, 0, 1, 1'b1);
    // Randomized configurations and handshakes
    for (int r = 0; r < 8; r++) begin
      int m;
      m = (r % 2 == 0) ? 2 : 1;
      run_sweep($urandom, $urandom, $urandom_range(1, 4), $urandom_range(0, 5), m, m == 1);
    end

    // Abort during step 1 dwell, then restart from step 0
    begin : abort_test
      bit seen;
      int d0;
      mode = 0;
      chk_prime = 1'b1;
      pre_cnt = 0;
      push_sweep(32'h0100_0000, 32'h0010_0000, 3, 4, 1);
      d0 = done_seen;
      issue_start(32'h0100_0000, 32'h0010_0000, 3, 4);
      seen = 1'b0;
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        if (sample_valid && step_idx == 1) begin seen = 1'b1; break; end
      end
      chk("abort_reach_step1", seen, 1);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_idx_held", step_idx, 1);
      chk("abort_phi_held", phi_inc_o, 32'h0110_0000);
      chk("abort_clken", nco_clken, 0);
      repeat (10) tick();
      chk("abort_no_done", done_seen - d0, 0);
      chk("abort_stays_idle", busy, 0);
      exp_q.delete();
      pre_cnt = 0;
    end
    run_sweep(32'h0100_0000, 32'h0010_0000, 3, 4, 0, 1'b1);

    // Abort together with start in IDLE: no sweep
    cfg_start_inc = 32'h1234_0000;
    cfg_step_inc  = 32'h1;
    cfg_nsteps    = 16'd2;
    cfg_dwell     = 16'd1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    repeat (3) tick();
    chk("abort_beats_start", busy, 0);
`endif

    // Reset mid-PRIME, then a zero-length start
    begin : reset_test
      int s0;
      mode = 0;
      issue_start(32'h0200_0000, 32'h0001_0000, 3, 2);
      tick();
      tick();
      chk("prime_busy_before_reset", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_phi", phi_inc_o, 0);
      chk("async_rst_clken", nco_clken, 0);
      chk("async_rst_sv", sample_valid, 0);
      chk("async_rst_idx", step_idx, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_done", done, 0);
      #3 reset_n = 1'b1;
      exp_q.delete();
      pre_cnt = 0;
      repeat (3) tick();
      chk("idle_after_reset", busy, 0);
      s0 = samp_seen;
      issue_start(32'h0300_0000, 32'h0001_0000, 0, 2);
      repeat (10) tick();
      chk("nsteps0_ignored", busy, 0);
      chk("nsteps0_no_samples", samp_seen - s0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
